// File: rtl/disk_loader_pkg.sv
// rtl/disk_loader_pkg.sv - shared types and LBA helper for the disk track loader
package disk_loader_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_REQ,
    ST_ACK_HI,
    ST_ACK_LO
  } state_t;

  typedef enum logic {
    MODE_RD,
    MODE_WB
  } mode_t;

  // spt is always a constant at the call site, so the shift-add loop folds into a few adders.
  function automatic logic [63:0] lba_of(input logic [31:0] trk, input logic [31:0] sec,
                                         input int unsigned spt);
    logic [63:0] acc;
    logic [31:0] mul;
    mul = 32'(spt);
    acc = {32'd0, sec};
    for (int i = 0; i < 32; i++) begin
      if (mul[i]) acc = acc + ({32'd0, trk} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/disk_track_loader_rr_arbiter.sv
// rtl/disk_track_loader_rr_arbiter.sv - round-robin pick of the first requester at or after ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  logic          lo_v, hi_v;
  logic [IW-1:0] lo_g, hi_g;

  // Descending scan: the last hit written is the lowest index in each half.
  always_comb begin
    lo_v = 1'b0;
    hi_v = 1'b0;
    lo_g = '0;
    hi_g = '0;
    for (int d = N - 1; d >= 0; d--) begin
      if (req[d]) begin
        lo_v = 1'b1;
        lo_g = IW'(d);
        if (IW'(d) >= ptr) begin
          hi_v = 1'b1;
          hi_g = IW'(d);
        end
      end
    end
    valid = lo_v;
    grant = hi_v ? hi_g : lo_g;
  end

endmodule

// File: rtl/disk_track_loader.sv
// rtl/disk_track_loader.sv - multi-drive floppy track loader over the hps_io sd handshake
module disk_track_loader
  import disk_loader_pkg::*;
#(
  parameter int NDRIVES        = 2,
  parameter int SECS_PER_TRACK = 13,
  parameter int TRACK_W        = 6,
  parameter int LBA_W          = 32
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic [NDRIVES*TRACK_W-1:0]   track,
  input  logic [NDRIVES-1:0]           dirty_set,
  input  logic [NDRIVES-1:0]           img_mounted,
  input  logic [NDRIVES-1:0]           img_present,
  input  logic [NDRIVES-1:0]           img_readonly,
  output logic [NDRIVES*LBA_W-1:0]     sd_lba,
  output logic [NDRIVES-1:0]           sd_rd,
  output logic [NDRIVES-1:0]           sd_wr,
  input  logic [NDRIVES-1:0]           sd_ack,
  output logic [$clog2(SECS_PER_TRACK)-1:0] buf_sec,
  output logic [NDRIVES-1:0]           cpu_wait,
  output logic                         busy
);

  localparam int IW = (NDRIVES > 1) ? $clog2(NDRIVES) : 1;
  localparam int SW = $clog2(SECS_PER_TRACK);
  localparam logic [SW-1:0] LAST_SEC = SW'(SECS_PER_TRACK - 1);
  localparam logic [IW-1:0] LAST_DRV = IW'(NDRIVES - 1);

  state_t              state;
  mode_t               mode;
  logic [IW-1:0]       act, rr_ptr, grant;
  logic                grant_valid;
  logic [TRACK_W-1:0]  cur_track [NDRIVES];
  logic [TRACK_W-1:0]  trk_in    [NDRIVES];
  logic [TRACK_W-1:0]  lat_track, lba_trk;
  logic [LBA_W-1:0]    lba_q     [NDRIVES];
  logic [LBA_W-1:0]    lba_next;
  logic [NDRIVES-1:0]  cur_valid, dirty, mount_pend, need, active;
  logic                op_busy;

  for (genvar g = 0; g < NDRIVES; g++) begin : g_flat
    assign trk_in[g]                  = track[g*TRACK_W +: TRACK_W];
    assign sd_lba[g*LBA_W +: LBA_W]   = lba_q[g];
  end

  assign op_busy = (state == ST_REQ) || (state == ST_ACK_HI) || (state == ST_ACK_LO);

  always_comb begin
    need   = '0;
    active = '0;
    for (int d = 0; d < NDRIVES; d++) begin
      need[d]   = img_present[d] & (~cur_valid[d] | (cur_track[d] != trk_in[d]));
      active[d] = op_busy && (act == IW'(d));
    end
  end

  // Write-back targets the track still held in the buffer; reads target the latched new track.
  assign lba_trk  = (mode == MODE_WB) ? cur_track[act] : lat_track;
  assign lba_next = LBA_W'(lba_of(32'(lba_trk), 32'(buf_sec), SECS_PER_TRACK));

  rr_arbiter #(.N(NDRIVES), .IW(IW)) u_arb (
    .req   (need),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_DRAIN;
      mode       <= MODE_RD;
      act        <= '0;
      rr_ptr     <= '0;
      lat_track  <= '0;
      buf_sec    <= '0;
      cur_valid  <= '0;
      dirty      <= '0;
      mount_pend <= '0;
      sd_rd      <= '0;
      sd_wr      <= '0;
      cpu_wait   <= '0;
      busy       <= 1'b0;
      for (int d = 0; d < NDRIVES; d++) begin
        cur_track[d] <= '0;
        lba_q[d]     <= '0;
      end
    end else begin
      // A mount on the drive being serviced only takes effect once its op completes.
      for (int d = 0; d < NDRIVES; d++) begin
        if (img_mounted[d]) begin
          cur_valid[d] <= 1'b0;
          dirty[d]     <= 1'b0;
          if (active[d]) mount_pend[d] <= 1'b1;
        end else if (dirty_set[d] && !img_readonly[d] && !active[d]) begin
          dirty[d] <= 1'b1;
        end
      end

      case (state)
        ST_DRAIN: begin
          if (sd_ack == '0) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (grant_valid) begin
            act             <= grant;
            rr_ptr          <= (grant == LAST_DRV) ? '0 : grant + 1'b1;
            mode            <= (dirty[grant] && cur_valid[grant] && !img_mounted[grant])
                               ? MODE_WB : MODE_RD;
            lat_track       <= trk_in[grant];
            buf_sec         <= '0;
            cpu_wait[grant] <= 1'b1;
            busy            <= 1'b1;
            state           <= ST_REQ;
          end
        end
        ST_REQ: begin
          lba_q[act] <= lba_next;
          if (mode == MODE_WB) sd_wr[act] <= 1'b1;
          else                 sd_rd[act] <= 1'b1;
          state <= ST_ACK_HI;
        end
        ST_ACK_HI: begin
          if (sd_ack[act]) begin
            sd_rd <= '0;
            sd_wr <= '0;
            state <= ST_ACK_LO;
          end
        end
        ST_ACK_LO: begin
          if (!sd_ack[act]) begin
            if (buf_sec != LAST_SEC) begin
              buf_sec <= buf_sec + 1'b1;
              state   <= ST_REQ;
            end else if (mode == MODE_WB) begin
              dirty[act] <= 1'b0;
              mode       <= MODE_RD;
              buf_sec    <= '0;
              state      <= ST_REQ;
            end else begin
              cur_track[act]  <= lat_track;
              cur_valid[act]  <= ~(mount_pend[act] | img_mounted[act]);
              mount_pend[act] <= 1'b0;
              cpu_wait[act]   <= 1'b0;
              busy            <= 1'b0;
              state           <= ST_IDLE;
            end
          end
        end
        default: state <= ST_DRAIN;
      endcase
    end
  end

endmodule
